// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ADD/SUB/MUL and an N-cycle restoring divider.
// One operation in flight; the result is held in DONE until the consumer takes it.
module alu_pipe #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op_code,
  input  logic [N-1:0]   inp1,
  input  logic [N-1:0]   inp2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] outp,
  output logic           err,
  output logic           busy
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e         state_q;
  logic [N-1:0]   rem_q;
  logic [N-1:0]   quo_q;
  logic [N-1:0]   dvs_q;
  logic [CW-1:0]  cnt_q;

  logic           accept;
  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [2*N-1:0] prod;
  logic [N:0]     rem_shift;
  logic [N:0]     trial;
  logic [N-1:0]   rem_next;
  logic [N-1:0]   quo_next;

  always_comb begin
    in_ready  = !reset && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
    accept    = in_valid && in_ready;
    sum       = {1'b0, inp1} + {1'b0, inp2};
    // Bit N of the wide difference is the borrow.
    diff      = {1'b0, inp1} - {1'b0, inp2};
    prod      = {{N{1'b0}}, inp1} * {{N{1'b0}}, inp2};
    // Restoring step: shift in the next dividend bit, subtract if it fits.
    rem_shift = {rem_q, quo_q[N-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    rem_next  = trial[N] ? rem_shift[N-1:0] : trial[N-1:0];
    quo_next  = {quo_q[N-2:0], ~trial[N]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      outp      <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        StDiv: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_q   <= StDone;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            outp      <= {rem_next, quo_next};
          end
        end
        default: begin
          if (accept) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
            err       <= 1'b0;
            unique case (op_code)
              2'b00: outp <= {{(N-1){1'b0}}, sum};
              2'b01: outp <= {{(N-1){1'b0}}, diff};
              2'b10: outp <= prod;
              2'b11: begin
                if (inp2 == '0) begin
                  outp <= {inp1, {N{1'b1}}};
                  err  <= 1'b1;
                end else begin
                  state_q   <= StDiv;
                  busy      <= 1'b1;
                  out_valid <= 1'b0;
                  rem_q     <= '0;
                  quo_q     <= inp1;
                  dvs_q     <= inp2;
                  cnt_q     <= '0;
                end
              end
            endcase
          end else if ((state_q == StDone) && out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (N=4): directed cases plus random ops against an arithmetic model.
module tb_alu_pipe;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     op_code;
  logic [N-1:0]   inp1;
  logic [N-1:0]   inp2;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] outp;
  logic           err;
  logic           busy;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .inp1      (inp1),
    .inp2      (inp2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {err, outp} from the arithmetic definition of each op.
  function automatic logic [8:0] model(input logic [1:0] op, input int a, input int b);
    int r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = ((a - b) & 15) + ((a < b) ? 16 : 0);
      2'd2:    r = a * b;
      default: r = (b == 0) ? (256 + a * 16 + 15) : ((a % b) * 16 + a / b);
    endcase
    return 9'(r);
  endfunction

  // Called at a negedge with the block idle and out_ready high.
  task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [8:0] exp;
    int         lat;
    int         exp_lat;
    bit         is_div;
    exp     = model(op, int'(a), int'(b));
    is_div  = (op == 2'd3) && (b != 0);
    exp_lat = is_div ? N + 1 : 1;
    in_valid = 1'b1; op_code = op; inp1 = a; inp2 = b;
    #1 check("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      check("busy_run", 32'(busy), 32'(is_div));
      check("in_ready_run", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("outp", 32'(outp), 32'(exp[7:0]));
    check("err", 32'(err), 32'(exp[8]));
    check("busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op_code = 2'd0; inp1 = '0; inp2 = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_outp", 32'(outp), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;

    // Directed vectors, expectations written out as constants.
    run_op(2'd0, 4'hF, 4'h1);
    check("add_F_1", 32'(outp), 32'h10);
    run_op(2'd3, 4'd13, 4'd4);
    check("div_13_4", 32'(outp), 32'h13);
    run_op(2'd3, 4'd7, 4'd0);
    check("div_7_0", 32'(outp), 32'h7F);
    run_op(2'd0, 4'd1, 4'd1);
    check("add_1_1", 32'(outp), 32'h02);
    check("add_1_1_err", 32'(err), 32'd0);

    // Back-to-back SUB then MUL.
    in_valid = 1'b1; op_code = 2'd1; inp1 = 4'd3; inp2 = 4'd5;
    #1 check("b2b_ready0", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("b2b_sub_valid", 32'(out_valid), 32'd1);
    check("b2b_sub", 32'(outp), 32'h1E);
    op_code = 2'd2; inp1 = 4'hF; inp2 = 4'hF;
    #1 check("b2b_ready1", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("b2b_mul_valid", 32'(out_valid), 32'd1);
    check("b2b_mul", 32'(outp), 32'hE1);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_drop", 32'(out_valid), 32'd0);

    // Stall the consumer for 3 cycles while offering a competing request.
    out_ready = 1'b0;
    in_valid = 1'b1; op_code = 2'd2; inp1 = 4'hF; inp2 = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      op_code = 2'd0; inp1 = 4'd2; inp2 = 4'd3;
      #1 check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_outp", 32'(outp), 32'hE1);
      check("stall_err", 32'(err), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("stall_release", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("stall_no_ghost", 32'(out_valid), 32'd0);

    // Reset two cycles into DIV 15/2 must discard the operation.
    in_valid = 1'b1; op_code = 2'd3; inp1 = 4'd15; inp2 = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outp", 32'(outp), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy_clr", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1 check("abort_ready_rel", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(3, 0)), 4'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
